// File: rtl/exib_pkg.sv
// Shared definitions for the display-result sequencer: state encoding and defaults.
package exib_pkg;

   typedef enum logic [1:0] {
      StOcioso  = 2'd0,
      StCaptura = 2'd1,
      StRevisao = 2'd2,
      StFim     = 2'd3
   } estado_e;

   localparam int unsigned NInstrDef  = 16;
   localparam logic [31:0] EndCodeDef = 32'h05F5E0FF;

endpackage

// File: rtl/exib_sequenciador_if.sv
// Single-port synchronous-read RAM bus between the sequencer (master) and the result memory.
interface exib_sequenciador_if #(
   parameter int unsigned ADDR_W = 5
) ();

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
   modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);

endinterface

// File: rtl/exib_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability filter and rising-edge pulse.
module exib_debounce #(
   parameter int unsigned DEB_CYCLES = 50000
) (
   input  logic Clk,
   input  logic reset,
   input  logic proximo,
   output logic passo
);

   localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            level_dly_q;
   logic            passo_q, passo_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // The level only flips after DEB_CYCLES consecutive disagreeing samples.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntMax) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      passo_d = level_q & ~level_dly_q;
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         cnt_q       <= '0;
         passo_q     <= 1'b0;
      end else begin
         sync1_q     <= proximo;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         cnt_q       <= cnt_d;
         passo_q     <= passo_d;
      end
   end

   assign passo = passo_q;

endmodule

// File: rtl/exib_sequenciador.sv
// Captures N_INSTR ALU results into RAM, then replays them one per button press,
// ending with END_CODE and wrapping back to word 0.
module exib_sequenciador
   import exib_pkg::*;
#(
   parameter int unsigned N_INSTR    = NInstrDef,
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned DEB_CYCLES = 50000,
   parameter logic [31:0] END_CODE   = EndCodeDef
) (
   input  logic                       Clk,
   input  logic                       reset,
   input  logic                       inicio,
   input  logic                       valido,
   input  logic [31:0]                resultadoALU,
   input  logic                       proximo,
   exib_sequenciador_if.master        mem,
   output logic [31:0]                saida,
   output logic                       fim,
   output logic [1:0]                 estado
);

   typedef logic [ADDR_W:0] cnt_t;
   localparam cnt_t LastWr = cnt_t'(N_INSTR - 1);
   localparam cnt_t NWords = cnt_t'(N_INSTR);

   logic passo;

   exib_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_debounce (
      .Clk    (Clk),
      .reset  (reset),
      .proximo(proximo),
      .passo  (passo)
   );

   estado_e           estado_q, estado_d;
   cnt_t              wr_cnt_q, wr_cnt_d;
   cnt_t              rd_cnt_q, rd_cnt_d;
   logic [1:0]        rd_stage_q, rd_stage_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       saida_q, saida_d;
   logic              fim_q, fim_d;

   always_comb begin
      estado_d    = estado_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      rd_stage_d  = rd_stage_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      saida_d     = saida_q;
      fim_d       = fim_q;
      case (estado_q)
         StOcioso: begin
            if (inicio) begin
               estado_d = StCaptura;
               wr_cnt_d = '0;
            end
         end
         StCaptura: begin
            if (valido) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = wr_cnt_q[ADDR_W-1:0];
               mem_wdata_d = resultadoALU;
               wr_cnt_d    = wr_cnt_q + 1'b1;
               if (wr_cnt_q == LastWr) begin
                  estado_d = StRevisao;
                  rd_cnt_d = '0;
               end
            end
         end
         StRevisao: begin
            if (inicio) begin
               estado_d   = StCaptura;
               wr_cnt_d   = '0;
               fim_d      = 1'b0;
               rd_stage_d = 2'd0;
            end else if (rd_stage_q == 2'd1) begin
               rd_stage_d = 2'd2;
            end else if (rd_stage_q == 2'd2) begin
               // RAM data for the address issued two edges ago is valid now.
               saida_d    = mem.mem_rdata;
               rd_stage_d = 2'd0;
            end else if (passo) begin
               if (rd_cnt_q == NWords) begin
                  estado_d = StFim;
                  saida_d  = END_CODE;
                  fim_d    = 1'b1;
               end else begin
                  mem_addr_d = rd_cnt_q[ADDR_W-1:0];
                  rd_cnt_d   = rd_cnt_q + 1'b1;
                  rd_stage_d = 2'd1;
               end
            end
         end
         StFim: begin
            if (inicio) begin
               estado_d   = StCaptura;
               wr_cnt_d   = '0;
               fim_d      = 1'b0;
               rd_stage_d = 2'd0;
            end else if (passo) begin
               // Wrap: the same press also launches the read of word 0.
               estado_d   = StRevisao;
               fim_d      = 1'b0;
               mem_addr_d = '0;
               rd_cnt_d   = cnt_t'(1);
               rd_stage_d = 2'd1;
            end
         end
         default: estado_d = StOcioso;
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         estado_q    <= StOcioso;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         rd_stage_q  <= 2'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         saida_q     <= '0;
         fim_q       <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_stage_q  <= rd_stage_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         saida_q     <= saida_d;
         fim_q       <= fim_d;
      end
   end

   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;
   assign saida         = saida_q;
   assign fim           = fim_q;
   assign estado        = estado_q;

endmodule
